axis_frame_source: RTL and testbench

//  AXI-Stream transmitter that produces the sample frames our skid buffer stage consumes.

---
 rtl/axis_frame_source_pkg.sv | 16 +
 rtl/axis_frame_source_if.sv | 26 ++
 rtl/axis_frame_source.sv | 96 +++++++++
 tb/tb_axis_frame_source.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_frame_source_pkg.sv
// Shared types for the AXI-Stream frame source: the frame config word and FSM states.
package axis_frame_source_pkg;

    typedef struct packed {
        logic [3:0] n;
    } config_k;

    typedef enum logic [1:0] {
        S_UNCFG = 2'd0,
        S_IDLE  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam int BEAT_CNT_WIDTH = 16;

endpackage

// File: rtl/axis_frame_source_if.sv
// AXI-Stream beat channel between the frame source (master) and its consumer (slave).
interface axis_frame_source_if #(
    parameter int DATA_WIDTH = 16
) ();
    import axis_frame_source_pkg::*;

    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/axis_frame_source.sv
// Emits frames of 2^n ramp-payload beats over AXI-Stream, one frame per accepted start.
module axis_frame_source
    import axis_frame_source_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int STEP       = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  config_k                config_r,
    input  logic                   config_valid,
    output logic                   config_ready,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  data_base,
    axis_frame_source_if.master    axis,
    output logic                   busy,
    output logic                   frame_done,
    output logic [3:0]             n_out,
    output logic [15:0]            total_samples
);

    state_t                    state;
    logic [3:0]                n_reg;
    logic [BEAT_CNT_WIDTH-1:0] beat_cnt;
    logic                      m_valid_q;
    logic [DATA_WIDTH-1:0]     m_data_q;
    logic                      m_last_q;
    logic                      frame_done_q;
    logic                      config_accept;
    logic [BEAT_CNT_WIDTH-1:0] last_index;
    logic [BEAT_CNT_WIDTH-1:0] next_cnt;

    assign config_ready  = (state != S_RUN);
    assign config_accept = config_valid && config_ready;
    assign total_samples = 16'(1) << n_reg;
    assign last_index    = total_samples - 16'd1;
    assign next_cnt      = beat_cnt + 16'd1;

    // The output data register doubles as the payload accumulator: each handshake
    // advances it by STEP, wrapping silently at DATA_WIDTH bits.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_UNCFG;
            n_reg        <= 4'd0;
            beat_cnt     <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                S_UNCFG: begin
                    if (config_accept) begin
                        n_reg <= config_r.n;
                        state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (config_accept) begin
                        n_reg <= config_r.n;
                    end else if (start) begin
                        state     <= S_RUN;
                        beat_cnt  <= '0;
                        m_valid_q <= 1'b1;
                        m_data_q  <= data_base;
                        m_last_q  <= (n_reg == 4'd0);
                    end
                end
                S_RUN: begin
                    if (m_valid_q && axis.m_ready) begin
                        if (m_last_q) begin
                            m_valid_q    <= 1'b0;
                            m_last_q     <= 1'b0;
                            frame_done_q <= 1'b1;
                            state        <= S_IDLE;
                        end else begin
                            beat_cnt <= next_cnt;
                            m_data_q <= m_data_q + DATA_WIDTH'(STEP);
                            m_last_q <= (next_cnt == last_index);
                        end
                    end
                end
                default: state <= S_UNCFG;
            endcase
        end
    end

    assign axis.m_valid = m_valid_q;
    assign axis.m_data  = m_data_q;
    assign axis.m_last  = m_last_q;
    assign busy         = (state == S_RUN);
    assign frame_done   = frame_done_q;
    assign n_out        = n_reg;

endmodule

// File: tb/tb_axis_frame_source.sv
// Directed bench for axis_frame_source: a STEP=1 instance and a STEP=3 instance for wrap.
module tb_axis_frame_source;
    import axis_frame_source_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    int          tests_run = 0;
    int          tests_failed = 0;

    config_k     cfg;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        start;
    logic [15:0] data_base;
    logic        busy;
    logic        frame_done;
    logic [3:0]  n_out;
    logic [15:0] total_samples;

    config_k     cfg3;
    logic        cfg_valid3;
    logic        cfg_ready3;
    logic        start3;
    logic [15:0] data_base3;
    logic        busy3;
    logic        frame_done3;
    logic [3:0]  n_out3;
    logic [15:0] total_samples3;

    axis_frame_source_if #(.DATA_WIDTH(16)) axis_if  ();
    axis_frame_source_if #(.DATA_WIDTH(16)) axis_if3 ();

    axis_frame_source #(.DATA_WIDTH(16), .STEP(1)) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .config_r      (cfg),
        .config_valid  (cfg_valid),
        .config_ready  (cfg_ready),
        .start         (start),
        .data_base     (data_base),
        .axis          (axis_if.master),
        .busy          (busy),
        .frame_done    (frame_done),
        .n_out         (n_out),
        .total_samples (total_samples)
    );

    axis_frame_source #(.DATA_WIDTH(16), .STEP(3)) u_dut3 (
        .clk           (clk),
        .reset_n       (reset_n),
        .config_r      (cfg3),
        .config_valid  (cfg_valid3),
        .config_ready  (cfg_ready3),
        .start         (start3),
        .data_base     (data_base3),
        .axis          (axis_if3.master),
        .busy          (busy3),
        .frame_done    (frame_done3),
        .n_out         (n_out3),
        .total_samples (total_samples3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    int          k;
    int          cycles;
    logic [15:0] exp_data;
    logic        ready_pattern [0:7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        reset_n = 1'b0;
        cfg = '0;        cfg_valid = 1'b0;  start = 1'b0;  data_base = '0;
        cfg3 = '0;       cfg_valid3 = 1'b0; start3 = 1'b0; data_base3 = '0;
        axis_if.m_ready = 1'b0;
        axis_if3.m_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check_output("rst_valid",  16'(axis_if.m_valid), 16'd0);
        check_output("rst_last",   16'(axis_if.m_last), 16'd0);
        check_output("rst_data",   axis_if.m_data, 16'h0000);
        check_output("rst_busy",   16'(busy), 16'd0);
        check_output("rst_done",   16'(frame_done), 16'd0);
        check_output("rst_n",      16'(n_out), 16'd0);
        check_output("rst_cready", 16'(cfg_ready), 16'd1);
        reset_n = 1'b1;

        // Test 1: n=2, base 0x0010, ready held high
        cfg.n = 4'd2; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check_output("t1_n",     16'(n_out), 16'd2);
        check_output("t1_total", total_samples, 16'd4);
        start = 1'b1; data_base = 16'h0010; axis_if.m_ready = 1'b1;
        tick();
        start = 1'b0;
        check_output("t1_busy", 16'(busy), 16'd1);
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("t1_valid%0d", i), 16'(axis_if.m_valid), 16'd1);
            check_output($sformatf("t1_data%0d", i), axis_if.m_data, 16'h0010 + 16'(i));
            check_output($sformatf("t1_last%0d", i), 16'(axis_if.m_last), (i == 3) ? 16'd1 : 16'd0);
            tick();
        end
        check_output("t1_done",      16'(frame_done), 16'd1);
        check_output("t1_valid_end", 16'(axis_if.m_valid), 16'd0);
        check_output("t1_busy_end",  16'(busy), 16'd0);
        tick();
        check_output("t1_done_pulse", 16'(frame_done), 16'd0);

        // Test 2: same frame with backpressure
        start = 1'b1; axis_if.m_ready = 1'b0;
        tick();
        start = 1'b0;
        k = 0;
        cycles = 0;
        while (k < 4 && cycles < 40) begin
            exp_data = 16'h0010 + 16'(k);
            check_output("t2_valid", 16'(axis_if.m_valid), 16'd1);
            check_output("t2_data",  axis_if.m_data, exp_data);
            check_output("t2_last",  16'(axis_if.m_last), (k == 3) ? 16'd1 : 16'd0);
            axis_if.m_ready = ready_pattern[cycles % 8];
            tick();
            if (ready_pattern[cycles % 8]) k++;
            cycles++;
        end
        check_output("t2_handshakes", 16'(k), 16'd4);
        check_output("t2_done",  16'(frame_done), 16'd1);
        check_output("t2_valid_end", 16'(axis_if.m_valid), 16'd0);

        // Test 3: n=0 single beat, start during the last handshake is dropped
        cfg.n = 4'd0; cfg_valid = 1'b1; axis_if.m_ready = 1'b0;
        tick();
        cfg_valid = 1'b0;
        check_output("t3_total", total_samples, 16'd1);
        start = 1'b1; data_base = 16'hABCD;
        tick();
        check_output("t3_valid", 16'(axis_if.m_valid), 16'd1);
        check_output("t3_data",  axis_if.m_data, 16'hABCD);
        check_output("t3_last",  16'(axis_if.m_last), 16'd1);
        axis_if.m_ready = 1'b1;
        tick();
        start = 1'b0;
        check_output("t3_done",  16'(frame_done), 16'd1);
        check_output("t3_valid_end", 16'(axis_if.m_valid), 16'd0);
        tick();
        check_output("t3_no_restart", 16'(axis_if.m_valid), 16'd0);

        // Test 4: STEP=3 instance wraps past 0xFFFF
        cfg3.n = 4'd1; cfg_valid3 = 1'b1;
        tick();
        cfg_valid3 = 1'b0;
        start3 = 1'b1; data_base3 = 16'hFFFE; axis_if3.m_ready = 1'b1;
        tick();
        start3 = 1'b0;
        check_output("t4_data0", axis_if3.m_data, 16'hFFFE);
        check_output("t4_last0", 16'(axis_if3.m_last), 16'd0);
        tick();
        check_output("t4_data1", axis_if3.m_data, 16'h0001);
        check_output("t4_last1", 16'(axis_if3.m_last), 16'd1);
        tick();
        check_output("t4_done",  16'(frame_done3), 16'd1);

        // Test 5: config wins over start in IDLE; config blocked in RUN
        cfg.n = 4'd3; cfg_valid = 1'b1; start = 1'b1; data_base = 16'h0100;
        axis_if.m_ready = 1'b0;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        check_output("t5_n",      16'(n_out), 16'd3);
        check_output("t5_nostart", 16'(axis_if.m_valid), 16'd0);
        check_output("t5_busy",   16'(busy), 16'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("t5_cready_run", 16'(cfg_ready), 16'd0);
        cfg.n = 4'd5; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check_output("t5_n_hold", 16'(n_out), 16'd3);
        check_output("t5_data_hold", axis_if.m_data, 16'h0100);

        // Test 6: reset in the middle of an 8-beat frame
        axis_if.m_ready = 1'b1;
        tick();
        tick();
        check_output("t6_beat2", axis_if.m_data, 16'h0102);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_output("t6_valid", 16'(axis_if.m_valid), 16'd0);
        check_output("t6_last",  16'(axis_if.m_last), 16'd0);
        check_output("t6_busy",  16'(busy), 16'd0);
        check_output("t6_cready", 16'(cfg_ready), 16'd1);
        check_output("t6_n",     16'(n_out), 16'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("t6_uncfg_start", 16'(axis_if.m_valid), 16'd0);
        cfg.n = 4'd1; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start = 1'b1; data_base = 16'h0042;
        tick();
        start = 1'b0;
        check_output("t6_restart_valid", 16'(axis_if.m_valid), 16'd1);
        check_output("t6_restart_data",  axis_if.m_data, 16'h0042);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
